// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first over a
// valid/ready handshake, repeating it rep+1 times, then pulses done.
module seq_pattern_tx #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] rep,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] sh;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [REP_W-1:0] pass;

    logic [LEN_W-1:0] len_eff;
    logic [PAT_W-1:0] pat_al;

    // Left-align the pattern so bit [len_eff-1] lands in the MSB; shifting then
    // always reads from the top regardless of length.
    assign len_eff = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    assign pat_al  = pattern << (LEN_W'(PAT_W) - len_eff);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pat_q     <= '0;
            sh        <= '0;
            len_q     <= '0;
            cnt       <= '0;
            pass      <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && len != '0) begin
                        pat_q     <= pat_al;
                        out       <= pat_al[PAT_W-1];
                        sh        <= pat_al << 1;
                        len_q     <= len_eff;
                        cnt       <= len_eff - LEN_W'(1);
                        pass      <= rep;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (cnt != '0) begin
                            cnt <= cnt - LEN_W'(1);
                            out <= sh[PAT_W-1];
                            sh  <= sh << 1;
                        end else if (pass != '0) begin
                            // Reload with no bubble between passes.
                            pass <= pass - REP_W'(1);
                            cnt  <= len_q - LEN_W'(1);
                            out  <= pat_q[PAT_W-1];
                            sh   <= pat_q << 1;
                        end else begin
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: hand-computed bit streams, stalls,
// boundary lengths, ignored starts and mid-transfer reset.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rep;
    logic       out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [63:0] bits;
    int          nb, nd, gaps, held;

    seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .REP_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .rep(rep), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {out, out_valid, busy, done}, 4'b0000);
    endtask

    // Runs one transfer, collecting accepted bits. Optional stall of stall_n
    // cycles once stall_at bits are accepted, optional start pokes in SEND/DONE.
    task automatic xfer(input logic [7:0] p, input int l, input int r,
                        input int stall_at, input int stall_n, input int poke,
                        output logic [63:0] b, output int n, output int ndone,
                        output int ngap, output int hval);
        int leff, stalled, hold;
        leff = (l > 8) ? 8 : l;
        b = '0; n = 0; ndone = 0; ngap = 0; stalled = 0; hval = -1; hold = 0;
        pattern = p; len = 4'(l); rep = 4'(r); start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; pattern = ~p; len = 4'd1; rep = 4'd0;
        chk("first_bit", {out_valid, busy, out}, {2'b11, p[leff-1]});
        for (int cyc = 0; cyc < 300; cyc++) begin
            start = 1'b0;
            if (poke > 0 && cyc == poke) start = 1'b1;
            if (stall_n > 0 && n == stall_at && stalled < stall_n) begin
                out_ready = 1'b0;
                if (stalled == 0) hold = out;
                chk("stall_hold", {out_valid, out}, {1'b1, 1'(hold)});
                stalled++;
                hval = hold;
            end else begin
                out_ready = 1'b1;
            end
            if (busy && !out_valid) ngap++;
            if (out_valid && out_ready) begin
                b = {b[62:0], out};
                n++;
            end
            if (done) begin
                ndone++;
                if (poke > 0) start = 1'b1;
            end
            if (ndone > 0 && !done) break;
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; pattern = 8'h0B; len = 4'd4; rep = 4'd0;
        out_ready = 1'b1;

        // reset wins over start
        step(); chk_idle("reset_c1");
        step(); chk_idle("reset_c2");
        reset = 1'b0; start = 1'b0;
        step(); chk_idle("after_reset");

        // basic 1011
        xfer(8'h0B, 4, 0, -1, 0, 0, bits, nb, nd, gaps, held);
        chk("basic_bits", bits, 64'hB);
        chk("basic_n", 64'(nb), 64'd4);
        chk("basic_done", 64'(nd), 64'd1);
        chk_idle("basic_idle");

        // repeat 110 x3, no bubbles, one done cycle
        xfer(8'h06, 3, 2, -1, 0, 0, bits, nb, nd, gaps, held);
        chk("rep_bits", bits, 64'h1B6);
        chk("rep_n", 64'(nb), 64'd9);
        chk("rep_gaps", 64'(gaps), 64'd0);
        chk("rep_done", 64'(nd), 64'd1);

        // back-pressure while the second bit (0) is presented
        xfer(8'hA5, 8, 0, 1, 3, 0, bits, nb, nd, gaps, held);
        chk("bp_held", 64'(held), 64'd0);
        chk("bp_bits", bits, 64'hA5);
        chk("bp_n", 64'(nb), 64'd8);

        // len=0 is ignored
        pattern = 8'hFF; len = 4'd0; start = 1'b1;
        step(); start = 1'b0;
        chk_idle("len0_c1");
        step(); chk_idle("len0_c2");

        // len=15 clamps to 8
        xfer(8'hC3, 15, 0, -1, 0, 0, bits, nb, nd, gaps, held);
        chk("clamp_bits", bits, 64'hC3);
        chk("clamp_n", 64'(nb), 64'd8);

        // start pokes during SEND and DONE
        xfer(8'h5A, 8, 1, -1, 0, 3, bits, nb, nd, gaps, held);
        chk("poke_bits", bits, 64'h5A5A);
        chk("poke_n", 64'(nb), 64'd16);
        chk("poke_done", 64'(nd), 64'd1);
        step(); chk_idle("poke_no_restart");

        // len=1 boundary
        xfer(8'h01, 1, 0, -1, 0, 0, bits, nb, nd, gaps, held);
        chk("len1_bits", bits, 64'h1);
        chk("len1_n", 64'(nb), 64'd1);
        chk("len1_done", 64'(nd), 64'd1);

        // reset after 3rd accepted bit
        pattern = 8'hE1; len = 4'd8; rep = 4'd0; start = 1'b1; out_ready = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        chk("mid_busy", {busy, out_valid}, 2'b11);
        reset = 1'b1;
        step(); chk_idle("mid_reset");
        reset = 1'b0;
        step(); chk_idle("mid_no_done");
        xfer(8'hE1, 8, 0, -1, 0, 0, bits, nb, nd, gaps, held);
        chk("mid_fresh_bits", bits, 64'hE1);
        chk("mid_fresh_n", 64'(nb), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
